memd_pipe: RTL
==============

Name: memd_pipe

Overview:
- Parametrised single-port data memory for the core's load/store path.
- Adds the following over a flat combinational-read array:
  - configurable pipelined read latency
  - per-byte write enables
  - a valid/ready request handshake
  - out-of-range address detection
  - a sequential hardware clear after reset, replacing a same-cycle array reset.
- Sits between the LSU and the data array; responses return in order at fixed latency.

Parameters:
- DATA_W, 32: data word width in bits; must be a multiple of 8.
- ADDR_W, 10: word-address width.
- DEPTH, 1024: number of words; must satisfy 1 <= DEPTH <= 2^ADDR_W.
- RD_LAT, 1: read latency in cycles, legal range 1..4.
- INIT_CLEAR, 1: 1 = zero the array sequentially after reset; 0 = skip the clear and leave contents undefined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_rdwt  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  word address.
- req_data  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte write enables; bit i controls bits [8i+7:8i].
- resp_valid  out  1  read data valid, single-cycle pulse per read.
- resp_data  out  DATA_W  read data.
- resp_err  out  1  qualifies resp_valid; 1 = read address >= DEPTH.
- init_done  out  1  high once the clear is complete and the block is in RUN.

Behaviour:
- Reset is synchronous, active-high, on clk.
- State machine states: CLEAR, RUN.
- On rst:
  - state <= CLEAR if INIT_CLEAR=1, else RUN.
  - clr_ptr <= 0.
  - All read-pipeline valid bits <= 0.
  - Outputs: req_ready=0, resp_valid=0, resp_err=0, resp_data=0, init_done=0.
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to array[clr_ptr], then clr_ptr <= clr_ptr+1.
  - On the cycle clr_ptr==DEPTH-1, that final word is written and state <= RUN.
  - The clear takes exactly DEPTH cycles after rst deasserts.
  - req_ready=0 throughout; requests are ignored, not queued.
- RUN state:
  - req_ready=1 and init_done=1, both registered outputs.
  - With INIT_CLEAR=0 they go high in the first cycle after rst deasserts.
- Accept condition: accept = req_valid && req_ready. Without accept, nothing changes.
- Write accept (req_rdwt=0):
  - At that clock edge, each byte lane with req_be[i]=1 is written; other lanes keep their value.
  - be=0 is a legal no-op.
  - No response is generated.
- Read accept (req_rdwt=1):
  - The array word is sampled at the accept edge and enters an RD_LAT-stage valid/data/err shift pipeline.
  - If accepted in cycle T, resp_valid=1 in cycle T+RD_LAT for exactly one cycle.
- Read-after-write:
  - A read accepted in the cycle after a write to the same address returns the new data.
  - A read and a write cannot share a cycle (single port).
- Throughput is one request per cycle. Back-to-back reads produce back-to-back responses in order.
- There is no response backpressure; the consumer must always accept.
- Out-of-range access (req_addr >= DEPTH, only possible when DEPTH < 2^ADDR_W):
  - Write: dropped, array unchanged.
  - Read: resp_data=0 and resp_err=1 with resp_valid.
- When resp_valid=0: resp_data holds its last value and resp_err=0.
- rst mid-operation:
  - In-flight reads are discarded; no resp_valid is issued for them.
  - The clear restarts from address 0.
- Width rules: byte-lane mask expansion uses DATA_W/8 lanes; clr_ptr is ADDR_W bits wide and is never compared beyond DEPTH-1.

Test Plan:
- Clear sequence (DEPTH=16, INIT_CLEAR=1): release rst, hold req_valid=1 -> req_ready=0 for 16 cycles, init_done=1 in cycle 16, then a read of any address returns 0.
- Byte-enable write (DATA_W=32): write 0xAABBCCDD be=1111 to addr 5, then 0x11223344 be=0101 to addr 5, then read -> resp_data=0xAA22CC44.
- Latency (RD_LAT=3): reads to addrs 1,2,3 accepted on consecutive cycles T..T+2 -> resp_valid high T+3..T+5 with data in order and no gaps; RD_LAT=1 -> responses at T+1..T+3.
- RAW: write 0xDEADBEEF to addr 7 in cycle T, read addr 7 in T+1 -> resp_data=0xDEADBEEF at T+1+RD_LAT.
- Out-of-range (DEPTH=12, ADDR_W=4): write to addr 13, then read addr 13 -> resp_valid=1, resp_err=1, resp_data=0; a subsequent read of addr 1 has resp_err=0 and addr 1 is unchanged.
- Reset mid-operation: issue 2 reads with RD_LAT=4, assert rst one cycle after the second accept -> no resp_valid ever fires for them, req_ready drops, clear restarts from 0.

Source files
------------

// File: rtl/memd_pipe.sv
// rtl/memd_pipe.sv - single-port data memory with byte enables, pipelined reads and post-reset clear
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   req_valid_i      request present; accepted when req_ready_o is also high
//   req_ready_o      registered; high only in RUN
//   req_rdwt_i       1 = read, 0 = write
//   req_addr_i       word address
//   req_data_i       write data
//   req_be_i         byte write enables, bit i covers bits [8i+7:8i]
//   resp_valid_o     one-cycle pulse per accepted read, RD_LAT cycles after accept
//   resp_data_o      read data; holds its last value between responses
//   resp_err_o       qualifies resp_valid_o; read address was >= DEPTH
//   init_done_o      registered; high once the clear has finished and the block is in RUN

module memd_pipe #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_rdwt_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                resp_valid_o,
    output logic [DATA_W-1:0]   resp_data_o,
    output logic                resp_err_o,
    output logic                init_done_o
);

    localparam int NB = DATA_W / 8;
    // One extra bit so DEPTH == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [RD_LAT-1:0]   vld_q;
    logic [RD_LAT-1:0]   err_q;
    logic [DATA_W-1:0]   dat_q [RD_LAT];

    logic                accept;
    logic                in_range;
    logic                clr_last;
    logic                clr_we;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_word;

    // The rst cycle is excluded so nothing lands in the array or the
    // read pipeline while the block is being reset.
    assign accept   = req_valid_i && ready_q && !rst;
    assign in_range = ({1'b0, req_addr_i} < DEPTH_W);
    assign clr_last = (clr_ptr_q == LAST_W);
    assign clr_we   = (state_q == CLEAR) && !rst;
    assign wr_en    = accept && !req_rdwt_i && in_range;
    assign rd_en    = accept && req_rdwt_i;

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem_q[req_addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (INIT_CLEAR != 0) ? CLEAR : RUN;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_last) begin
                    // Final word is written this cycle; ready/done rise next cycle.
                    state_d = RUN;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            RUN: begin
                ready_d = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Array has no reset; the CLEAR state zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be_i[i]) begin
                    mem_q[req_addr_i][8*i +: 8] <= req_data_i[8*i +: 8];
                end
            end
        end
    end

    // Data registers only load behind a valid entry, so the last stage
    // naturally holds the previous response between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            err_q[0] <= rd_en && !in_range;
            if (rd_en) begin
                dat_q[0] <= rd_word;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                err_q[k] <= err_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    assign req_ready_o  = ready_q;
    assign init_done_o  = done_q;
    assign resp_valid_o = vld_q[RD_LAT-1];
    assign resp_err_o   = vld_q[RD_LAT-1] && err_q[RD_LAT-1];
    assign resp_data_o  = dat_q[RD_LAT-1];

endmodule
